wav_dfi_lp_resp: RTL and testbench
==================================

Name: wav_dfi_lp_resp

Overview:
- PHY-side responder for the DFI low-power control interface. It is the opposite end of the MC-side lp_ctrl/lp_data request handshakes.
- Two independent channels (ctrl, data). Each channel samples req and wakeup from the MC, decides accept or decline, and drives ack with programmable response latency.
- Holds ack through a wakeup-exit period after req de-asserts.
- Sits between the DFI boundary and the PHY power-management logic; reports the low-power state to PHY core logic.

Parameters:
- ACK_DLY, 2, cycles from sampled req rise to ack assertion (1..TLP_RESP-1; elaboration error otherwise).
- TLP_RESP, 8, DFI tlp_resp: max cycles the MC waits for ack.
- WAKE_MAX, 31, clamp on exit-delay cycles derived from the wakeup code.

Ports:
- clock  in  1  DFI clock
- reset  in  1  async active-high reset
- lp_ctrl_req  in  1  MC ctrl low-power request
- lp_ctrl_wakeup  in  6  MC ctrl wakeup code
- lp_ctrl_ack  out  1  ctrl acknowledge
- lp_data_req  in  1  MC data low-power request
- lp_data_wakeup  in  6  MC data wakeup code
- lp_data_ack  out  1  data acknowledge
- ctrl_allow  in  1  PHY permits ctrl low-power entry
- data_allow  in  1  PHY permits data low-power entry
- ctrl_lp_active  out  1  ctrl channel in low power (ACK state)
- data_lp_active  out  1  data channel in low power (ACK state)
- ctrl_wake_code  out  6  latched ctrl wakeup code
- data_wake_code  out  6  latched data wakeup code
- lp_err  out  2  sticky {data,ctrl}: req held without ack for more than TLP_RESP cycles while declining

Behaviour:
- Reset (async assert, sync release): all outputs 0; both FSMs IDLE; counters 0.
- Per-channel FSM states: IDLE, RESP, ACK, EXIT, DECLINE.
- IDLE: ack=0.
  - req=1 & allow=1 → RESP; load cnt=ACK_DLY-1; latch wakeup.
  - req=1 & allow=0 → DECLINE; clear tcnt.
- RESP: cnt decrements each cycle.
  - req=0 → IDLE, no ack (abort).
  - cnt==0 & req=1 → ACK. ack=1 is registered, so it is first visible ACK_DLY cycles after the cycle req was sampled high.
- ACK: ack=1, lp_active=1.
  - Wakeup code re-latched every cycle while req=1.
  - req=0 → EXIT; load ecnt=min(wake_code+1, WAKE_MAX).
- EXIT: ack=1, lp_active=0. ecnt decrements; at ecnt==0, ack=0 next cycle and state → IDLE.
  - req re-assertion during EXIT is ignored. It is evaluated in IDLE, which guarantees at least 1 cycle of ack=0 between handshakes.
- DECLINE: ack stays 0.
  - tcnt increments (saturating) while req=1. On reaching TLP_RESP with req still 1, set lp_err bit (sticky until reset).
  - req=0 → IDLE.
  - allow rising during DECLINE does not accept; the MC must re-request.
- allow is sampled only in IDLE; it has no effect in RESP/ACK/EXIT.
- Channels are fully independent; simultaneous ctrl/data events are processed in the same cycle with no priority.
- Unknown (X) on req is treated as 0 in synthesis. The bench flags X separately.
- Async reset mid-handshake: ack drops immediately, and the FSM restarts in IDLE.

Optional Feature:
- WAV_DFI_LP_STATS_EN defined:
  - Adds out ports ctrl_entry_cnt[15:0] and data_entry_cnt[15:0].
  - Each counts RESP→ACK transitions, saturating at 16'hFFFF; reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package wav_dfi_lp_pkg:
  - lp_state_e enum (IDLE, RESP, ACK, EXIT, DECLINE).
  - WAKE_W=6.
  - Function wake_cycles(code, max) returning clamped exit delay.
- Sub-module wav_dfi_lp_chan: one channel FSM plus counters. Instantiated twice (ctrl, data) by wav_dfi_lp_resp, which only wires ports and gates the stats feature.

Test Plan:
- ctrl_allow=1, lp_ctrl_req rises at cycle 0, wakeup=3 → ack=1 at cycle 2. Drop req at cycle 10 → ack stays 1 for 4 cycles, then 0; ctrl_lp_active=1 only during ACK.
- data_allow=0, req held 12 cycles → ack never asserts, lp_err[1]=1 after cycle 8 and stays 1 after req drops; lp_err[0]=0.
- req pulses for 1 cycle with allow=1 → RESP abort, ack never asserts, FSM returns to IDLE.
- In ACK, wakeup changes 3→40 before req falls → exit delay=min(41,31)=31 cycles; ctrl_wake_code=40.
- req re-asserted during EXIT → ignored; new ack only after ≥1 cycle of ack=0 plus ACK_DLY; both channels run concurrently with no interference.
- reset asserted mid-ACK → ack=0 asynchronously; after release, req still high → new handshake from IDLE. With WAV_DFI_LP_STATS_EN, entry_cnt=1 per completed entry and reset to 0.

Source files
------------

// File: rtl/wav_dfi_lp_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wav_dfi_lp_pkg
// Brief    : Shared state type, widths and exit-delay helper for the DFI
//            low-power responder.
// Revision : 1.0 - initial release
// ============================================================================
package wav_dfi_lp_pkg;

    localparam int WAKE_W  = 6;
    localparam int ENTRY_W = 16;

    typedef logic [WAKE_W:0] wake_cnt_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RESP    = 3'd1,
        ACK     = 3'd2,
        EXIT    = 3'd3,
        DECLINE = 3'd4
    } lp_state_e;

    // Exit dwell is the wakeup code plus one, clamped to the configured ceiling.
    function automatic wake_cnt_t wake_cycles(input logic [WAKE_W-1:0] code,
                                              input int max_cycles);
        wake_cnt_t w_inc;
        w_inc = {1'b0, code} + wake_cnt_t'(1);
        if (int'(w_inc) > max_cycles) begin
            return wake_cnt_t'(max_cycles);
        end
        return w_inc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wav_dfi_lp_resp_if.sv
`default_nettype none
// ============================================================================
// Module   : wav_dfi_lp_resp_if
// Brief    : DFI lp_ctrl / lp_data request-acknowledge handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface wav_dfi_lp_resp_if;

    logic                               lp_ctrl_req;
    logic [wav_dfi_lp_pkg::WAKE_W-1:0]  lp_ctrl_wakeup;
    logic                               lp_ctrl_ack;
    logic                               lp_data_req;
    logic [wav_dfi_lp_pkg::WAKE_W-1:0]  lp_data_wakeup;
    logic                               lp_data_ack;

    modport master (
        output lp_ctrl_req, lp_ctrl_wakeup, lp_data_req, lp_data_wakeup,
        input  lp_ctrl_ack, lp_data_ack
    );

    modport slave (
        input  lp_ctrl_req, lp_ctrl_wakeup, lp_data_req, lp_data_wakeup,
        output lp_ctrl_ack, lp_data_ack
    );

endinterface
`default_nettype wire

// File: rtl/wav_dfi_lp_resp_chan.sv
`default_nettype none
// ============================================================================
// Module   : wav_dfi_lp_chan
// Brief    : One DFI low-power responder channel: accept/decline FSM with
//            response, exit and timeout counters. Entry counter present when
//            WAV_DFI_LP_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module wav_dfi_lp_chan
    import wav_dfi_lp_pkg::*;
#(
    parameter int ACK_DLY  = 2,
    parameter int TLP_RESP = 8,
    parameter int WAKE_MAX = 31
) (
    input  wire logic               clock,
    input  wire logic               reset,
    input  wire logic               i_req,
    input  wire logic [WAKE_W-1:0]  i_wakeup,
    input  wire logic               i_allow,
    output logic                    o_ack,
    output logic                    o_lp_active,
    output logic [WAKE_W-1:0]       o_wake_code,
    output logic                    o_err
`ifdef WAV_DFI_LP_STATS_EN
    ,
    output logic [ENTRY_W-1:0]      o_entry_cnt
`endif
);

    localparam int c_CNT_W  = (ACK_DLY > 1) ? $clog2(ACK_DLY) : 1;
    localparam int c_TCNT_W = $clog2(TLP_RESP + 1);

    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LOAD = c_CNT_W'(ACK_DLY - 1);
    localparam logic [c_TCNT_W-1:0] c_TCNT_ONE = c_TCNT_W'(1);
    localparam logic [c_TCNT_W-1:0] c_TLP      = c_TCNT_W'(TLP_RESP);
    localparam logic [c_TCNT_W-1:0] c_TLP_M1   = c_TCNT_W'(TLP_RESP - 1);
    localparam wake_cnt_t           c_ECNT_ONE = wake_cnt_t'(1);

    if (ACK_DLY < 1 || ACK_DLY >= TLP_RESP) begin : g_ack_dly_check
        $error("wav_dfi_lp_chan: ACK_DLY must lie in 1..TLP_RESP-1");
    end

    lp_state_e            r_state,     w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt,       w_cnt_nxt;
    wake_cnt_t            r_ecnt,      w_ecnt_nxt;
    logic [c_TCNT_W-1:0]  r_tcnt,      w_tcnt_nxt;
    logic [WAKE_W-1:0]    r_wake_code, w_code_nxt;
    logic                 r_err,       w_err_nxt;
    logic                 r_ack;
    logic                 r_lp_active;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_ecnt      <= '0;
            r_tcnt      <= '0;
            r_wake_code <= '0;
            r_err       <= 1'b0;
            r_ack       <= 1'b0;
            r_lp_active <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ecnt      <= w_ecnt_nxt;
            r_tcnt      <= w_tcnt_nxt;
            r_wake_code <= w_code_nxt;
            r_err       <= w_err_nxt;
            r_ack       <= (w_state_nxt == ACK) || (w_state_nxt == EXIT);
            r_lp_active <= (w_state_nxt == ACK);
        end
    end

    // ack is registered from the next state, so RESP dwells ACK_DLY-1 cycles
    // and EXIT dwells exactly the computed exit delay.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ecnt_nxt  = r_ecnt;
        w_tcnt_nxt  = r_tcnt;
        w_code_nxt  = r_wake_code;
        w_err_nxt   = r_err;
        case (r_state)
            IDLE: begin
                if (i_req) begin
                    if (i_allow) begin
                        w_code_nxt = i_wakeup;
                        if (ACK_DLY == 1) begin
                            w_state_nxt = ACK;
                        end else begin
                            w_state_nxt = RESP;
                            w_cnt_nxt   = c_CNT_LOAD;
                        end
                    end else begin
                        w_state_nxt = DECLINE;
                        w_tcnt_nxt  = '0;
                    end
                end
            end
            RESP: begin
                if (!i_req) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt <= c_CNT_ONE) begin
                    w_state_nxt = ACK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - c_CNT_ONE;
                end
            end
            ACK: begin
                if (i_req) begin
                    w_code_nxt  = i_wakeup;
                end else begin
                    w_state_nxt = EXIT;
                    w_ecnt_nxt  = wake_cycles(r_wake_code, WAKE_MAX);
                end
            end
            EXIT: begin
                // A new req is deliberately not looked at until IDLE.
                if (r_ecnt <= c_ECNT_ONE) begin
                    w_state_nxt = IDLE;
                    w_ecnt_nxt  = '0;
                end else begin
                    w_ecnt_nxt  = r_ecnt - c_ECNT_ONE;
                end
            end
            DECLINE: begin
                if (!i_req) begin
                    w_state_nxt = IDLE;
                end else begin
                    if (r_tcnt != c_TLP) begin
                        w_tcnt_nxt = r_tcnt + c_TCNT_ONE;
                    end
                    if (r_tcnt >= c_TLP_M1) begin
                        w_err_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_ack       = r_ack;
    assign o_lp_active = r_lp_active;
    assign o_wake_code = r_wake_code;
    assign o_err       = r_err;

`ifdef WAV_DFI_LP_STATS_EN
    logic               w_entry;
    logic [ENTRY_W-1:0] r_entry_cnt;

    assign w_entry = (w_state_nxt == ACK) && (r_state != ACK);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_entry_cnt <= '0;
        end else if (w_entry && (r_entry_cnt != '1)) begin
            r_entry_cnt <= r_entry_cnt + ENTRY_W'(1);
        end
    end

    assign o_entry_cnt = r_entry_cnt;
`endif

endmodule
`default_nettype wire

// File: rtl/wav_dfi_lp_resp.sv
`default_nettype none
// ============================================================================
// Module   : wav_dfi_lp_resp
// Brief    : PHY-side DFI low-power responder, independent ctrl and data
//            channels. Define WAV_DFI_LP_STATS_EN for per-channel entry counts.
// Revision : 1.0 - initial release
// ============================================================================
module wav_dfi_lp_resp
    import wav_dfi_lp_pkg::*;
#(
    parameter int ACK_DLY  = 2,
    parameter int TLP_RESP = 8,
    parameter int WAKE_MAX = 31
) (
    input  wire logic               clock,
    input  wire logic               reset,
    wav_dfi_lp_resp_if.slave        dfi,
    input  wire logic               ctrl_allow,
    input  wire logic               data_allow,
    output logic                    ctrl_lp_active,
    output logic                    data_lp_active,
    output logic [WAKE_W-1:0]       ctrl_wake_code,
    output logic [WAKE_W-1:0]       data_wake_code,
    output logic [1:0]              lp_err
`ifdef WAV_DFI_LP_STATS_EN
    ,
    output logic [ENTRY_W-1:0]      ctrl_entry_cnt,
    output logic [ENTRY_W-1:0]      data_entry_cnt
`endif
);

    logic w_ctrl_err;
    logic w_data_err;

    wav_dfi_lp_chan #(
        .ACK_DLY  (ACK_DLY),
        .TLP_RESP (TLP_RESP),
        .WAKE_MAX (WAKE_MAX)
    ) u_ctrl (
        .clock       (clock),
        .reset       (reset),
        .i_req       (dfi.lp_ctrl_req),
        .i_wakeup    (dfi.lp_ctrl_wakeup),
        .i_allow     (ctrl_allow),
        .o_ack       (dfi.lp_ctrl_ack),
        .o_lp_active (ctrl_lp_active),
        .o_wake_code (ctrl_wake_code),
        .o_err       (w_ctrl_err)
`ifdef WAV_DFI_LP_STATS_EN
        ,
        .o_entry_cnt (ctrl_entry_cnt)
`endif
    );

    wav_dfi_lp_chan #(
        .ACK_DLY  (ACK_DLY),
        .TLP_RESP (TLP_RESP),
        .WAKE_MAX (WAKE_MAX)
    ) u_data (
        .clock       (clock),
        .reset       (reset),
        .i_req       (dfi.lp_data_req),
        .i_wakeup    (dfi.lp_data_wakeup),
        .i_allow     (data_allow),
        .o_ack       (dfi.lp_data_ack),
        .o_lp_active (data_lp_active),
        .o_wake_code (data_wake_code),
        .o_err       (w_data_err)
`ifdef WAV_DFI_LP_STATS_EN
        ,
        .o_entry_cnt (data_entry_cnt)
`endif
    );

    assign lp_err = {w_data_err, w_ctrl_err};

endmodule
`default_nettype wire

// File: tb/tb_wav_dfi_lp_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_wav_dfi_lp_resp
// Brief    : Directed plus randomized bench for wav_dfi_lp_resp against a
//            time-stamp based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wav_dfi_lp_resp;
    import wav_dfi_lp_pkg::*;

    localparam int ACK_DLY  = 2;
    localparam int TLP_RESP = 8;
    localparam int WAKE_MAX = 31;

    localparam int c_M_IDLE = 0;
    localparam int c_M_WAIT = 1;
    localparam int c_M_LOW  = 2;
    localparam int c_M_EXIT = 3;
    localparam int c_M_DECL = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              ctrl_allow;
    logic              data_allow;
    logic              ctrl_lp_active;
    logic              data_lp_active;
    logic [WAKE_W-1:0] ctrl_wake_code;
    logic [WAKE_W-1:0] data_wake_code;
    logic [1:0]        lp_err;
`ifdef WAV_DFI_LP_STATS_EN
    logic [ENTRY_W-1:0] ctrl_entry_cnt;
    logic [ENTRY_W-1:0] data_entry_cnt;
`endif

    wav_dfi_lp_resp_if dfi ();

    wav_dfi_lp_resp #(
        .ACK_DLY  (ACK_DLY),
        .TLP_RESP (TLP_RESP),
        .WAKE_MAX (WAKE_MAX)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .dfi            (dfi.slave),
        .ctrl_allow     (ctrl_allow),
        .data_allow     (data_allow),
        .ctrl_lp_active (ctrl_lp_active),
        .data_lp_active (data_lp_active),
        .ctrl_wake_code (ctrl_wake_code),
        .data_wake_code (data_wake_code),
        .lp_err         (lp_err)
`ifdef WAV_DFI_LP_STATS_EN
        ,
        .ctrl_entry_cnt (ctrl_entry_cnt),
        .data_entry_cnt (data_entry_cnt)
`endif
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;
    int n_ack_hi = 0;

    // Stimulus registers, index 0 = ctrl, 1 = data.
    logic              dr_req[2];
    logic [WAKE_W-1:0] dr_wake[2];
    logic              dr_allow[2];

    // Reference model: phase plus absolute cycle stamps.
    int                m_mode[2];
    int                m_tacc[2];
    int                m_tend[2];
    int                m_hold[2];
    int                m_ent[2];
    logic              m_err[2];
    logic [WAKE_W-1:0] m_code[2];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            m_mode[ch] = c_M_IDLE;
            m_tacc[ch] = 0;
            m_tend[ch] = 0;
            m_hold[ch] = 0;
            m_ent[ch]  = 0;
            m_err[ch]  = 1'b0;
            m_code[ch] = '0;
        end
    endtask

    task automatic model_edge(input int ch, input logic req, input logic [WAKE_W-1:0] wake,
                              input logic allow);
        int n;
        case (m_mode[ch])
            c_M_IDLE: if (req === 1'b1) begin
                if (allow) begin
                    m_code[ch] = wake;
                    m_tacc[ch] = cyc;
                    if (ACK_DLY == 1) begin
                        m_mode[ch] = c_M_LOW;
                        m_ent[ch]++;
                    end else begin
                        m_mode[ch] = c_M_WAIT;
                    end
                end else begin
                    m_mode[ch] = c_M_DECL;
                    m_hold[ch] = 0;
                end
            end
            c_M_WAIT: if (req !== 1'b1) begin
                m_mode[ch] = c_M_IDLE;
            end else if (cyc - m_tacc[ch] >= ACK_DLY - 1) begin
                m_mode[ch] = c_M_LOW;
                m_ent[ch]++;
            end
            c_M_LOW: if (req === 1'b1) begin
                m_code[ch] = wake;
            end else begin
                n = int'(m_code[ch]) + 1;
                if (n > WAKE_MAX) n = WAKE_MAX;
                m_tend[ch] = cyc + n;
                m_mode[ch] = c_M_EXIT;
            end
            c_M_EXIT: if (cyc >= m_tend[ch]) m_mode[ch] = c_M_IDLE;
            c_M_DECL: if (req !== 1'b1) begin
                m_mode[ch] = c_M_IDLE;
            end else begin
                m_hold[ch]++;
                if (m_hold[ch] >= TLP_RESP) m_err[ch] = 1'b1;
            end
            default: m_mode[ch] = c_M_IDLE;
        endcase
    endtask

    task automatic check_all();
        chk("ctrl_ack",       16'(dfi.lp_ctrl_ack), 16'(m_mode[0] == c_M_LOW || m_mode[0] == c_M_EXIT));
        chk("data_ack",       16'(dfi.lp_data_ack), 16'(m_mode[1] == c_M_LOW || m_mode[1] == c_M_EXIT));
        chk("ctrl_lp_active", 16'(ctrl_lp_active),  16'(m_mode[0] == c_M_LOW));
        chk("data_lp_active", 16'(data_lp_active),  16'(m_mode[1] == c_M_LOW));
        chk("ctrl_wake_code", 16'(ctrl_wake_code),  16'(m_code[0]));
        chk("data_wake_code", 16'(data_wake_code),  16'(m_code[1]));
        chk("lp_err",         16'(lp_err),          16'({m_err[1], m_err[0]}));
`ifdef WAV_DFI_LP_STATS_EN
        chk("ctrl_entry_cnt", ctrl_entry_cnt, 16'(m_ent[0]));
        chk("data_entry_cnt", data_entry_cnt, 16'(m_ent[1]));
`endif
    endtask

    // Starts and ends at a falling edge; outputs are checked there.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            dfi.lp_ctrl_req    = dr_req[0];
            dfi.lp_ctrl_wakeup = dr_wake[0];
            ctrl_allow         = dr_allow[0];
            dfi.lp_data_req    = dr_req[1];
            dfi.lp_data_wakeup = dr_wake[1];
            data_allow         = dr_allow[1];
            @(posedge clock);
            cyc++;
            model_edge(0, dr_req[0], dr_wake[0], dr_allow[0]);
            model_edge(1, dr_req[1], dr_wake[1], dr_allow[1]);
            @(negedge clock);
            if (dfi.lp_ctrl_ack === 1'b1) n_ack_hi++;
            check_all();
        end
    endtask

    task automatic set_ch(input int ch, input logic req, input logic [WAKE_W-1:0] wake,
                          input logic allow);
        dr_req[ch]   = req;
        dr_wake[ch]  = wake;
        dr_allow[ch] = allow;
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set_ch(0, 1'b0, '0, 1'b0);
        set_ch(1, 1'b0, '0, 1'b0);
        dfi.lp_ctrl_req = 1'b0; dfi.lp_ctrl_wakeup = '0; ctrl_allow = 1'b0;
        dfi.lp_data_req = 1'b0; dfi.lp_data_wakeup = '0; data_allow = 1'b0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        check_all();
        reset = 1'b0;

        // Accept with wakeup 3: ack held 4 cycles into exit.
        n_ack_hi = 0;
        set_ch(0, 1'b1, 6'd3, 1'b1);
        tick(10);
        set_ch(0, 1'b0, 6'd3, 1'b1);
        tick(8);
        chk("t1_ack_cycles", 16'(n_ack_hi), 16'd13);
`ifdef WAV_DFI_LP_STATS_EN
        chk("t1_entry_cnt", ctrl_entry_cnt, 16'd1);
`endif

        // Data declined for 12 cycles: sticky timeout error.
        set_ch(1, 1'b1, 6'd7, 1'b0);
        tick(6);
        set_ch(1, 1'b1, 6'd7, 1'b1);
        tick(6);
        set_ch(1, 1'b0, 6'd7, 1'b1);
        tick(4);
        chk("t2_lp_err", 16'(lp_err), 16'b10);

        // One-cycle req pulse aborts in RESP.
        set_ch(0, 1'b1, 6'd5, 1'b1);
        tick(1);
        set_ch(0, 1'b0, 6'd5, 1'b1);
        tick(4);

        // Wakeup re-latched in ACK; exit clamps at WAKE_MAX.
        set_ch(0, 1'b1, 6'd3, 1'b1);
        tick(5);
        set_ch(0, 1'b1, 6'd40, 1'b1);
        tick(2);
        n_ack_hi = 0;
        set_ch(0, 1'b0, 6'd9, 1'b1);
        tick(35);
        chk("t4_exit_cycles", 16'(n_ack_hi), 16'd31);
        chk("t4_wake_code", 16'(ctrl_wake_code), 16'd40);

        // Re-request during exit, both channels running.
        set_ch(0, 1'b1, 6'd1, 1'b1);
        tick(1);
        set_ch(1, 1'b1, 6'd0, 1'b1);
        tick(5);
        set_ch(0, 1'b0, 6'd1, 1'b1);
        tick(1);
        set_ch(0, 1'b1, 6'd2, 1'b1);
        set_ch(1, 1'b0, 6'd0, 1'b1);
        tick(12);
        set_ch(0, 1'b0, 6'd2, 1'b1);
        tick(40);

        // Reset in ACK, req kept high across release.
        set_ch(0, 1'b1, 6'd4, 1'b1);
        set_ch(1, 1'b1, 6'd6, 1'b1);
        tick(6);
        async_reset();
        tick(6);
        chk("t6_ctrl_ack_again", 16'(dfi.lp_ctrl_ack), 16'd1);
`ifdef WAV_DFI_LP_STATS_EN
        chk("t6_entry_after_rst", ctrl_entry_cnt, 16'd1);
`endif
        set_ch(0, 1'b0, 6'd4, 1'b1);
        set_ch(1, 1'b0, 6'd6, 1'b1);
        tick(40);

        // Randomized traffic on both channels.
        for (int k = 0; k < 600; k++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if ($urandom_range(7) == 0) dr_req[ch] = ~dr_req[ch];
                dr_wake[ch]  = WAKE_W'($urandom_range(63));
                dr_allow[ch] = ($urandom_range(3) != 0);
            end
            tick(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
